sseg_scan_ctrl: RTL and testbench

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_pkg.sv | 23 ++
 rtl/seg_decode.sv | 31 +++
 rtl/sseg_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scanner: segment patterns {a,b,c,d,e,f,g} per code and the blank code.
package sseg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011101;  // 'o'
  localparam logic [6:0] SEG_C = 7'b0110111;  // 'H'
  localparam logic [6:0] SEG_D = 7'b0111101;  // 'd'
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b0000000;

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit code to seven-segment pattern decoder.
module seg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] sseg
);

  always_comb begin
    sseg = SEG_F;
    unique case (code)
      4'h0: sseg = SEG_0;
      4'h1: sseg = SEG_1;
      4'h2: sseg = SEG_2;
      4'h3: sseg = SEG_3;
      4'h4: sseg = SEG_4;
      4'h5: sseg = SEG_5;
      4'h6: sseg = SEG_6;
      4'h7: sseg = SEG_7;
      4'h8: sseg = SEG_8;
      4'h9: sseg = SEG_9;
      4'hA: sseg = SEG_A;
      4'hB: sseg = SEG_B;
      4'hC: sseg = SEG_C;
      4'hD: sseg = SEG_D;
      4'hE: sseg = SEG_E;
      4'hF: sseg = SEG_F;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous content update and blink.
// Define SSEG_SCAN_LZB_EN to blank leading zeros.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dots,
  input  logic [NDIG-1:0]   blink,
  output logic              ack,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        sseg,
  output logic              dot
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [FW-1:0]     frm_reg, frm_next;
  logic              phase_reg, phase_next;
  logic              pend_reg, pend_next;
  logic [4*NDIG-1:0] stg_dig_reg, stg_dig_next;
  logic [NDIG-1:0]   stg_dots_reg, stg_dots_next;
  logic [NDIG-1:0]   stg_blink_reg, stg_blink_next;
  logic [4*NDIG-1:0] act_dig_reg, act_dig_next;
  logic [NDIG-1:0]   act_dots_reg, act_dots_next;
  logic [NDIG-1:0]   act_blink_reg, act_blink_next;
  logic              ack_reg, ack_next;
  logic [NDIG-1:0]   an_reg, an_next;
  logic [6:0]        sseg_reg, sseg_next;
  logic              dot_reg, dot_next;

  logic              tick;
  logic              frame_end;
  logic              blink_blank;
  logic [3:0]        code_arr [NDIG];
  logic [3:0]        dec_code;
  logic [6:0]        dec_seg;

  assign tick      = (cnt_reg == CNT_MAX);
  assign frame_end = tick && (idx_reg == IDX_MAX);

  // Scan, blink and staging/commit state.
  always_comb begin
    cnt_next       = tick ? '0 : cnt_reg + 1'b1;
    idx_next       = idx_reg;
    frm_next       = frm_reg;
    phase_next     = phase_reg;
    pend_next      = pend_reg;
    stg_dig_next   = stg_dig_reg;
    stg_dots_next  = stg_dots_reg;
    stg_blink_next = stg_blink_reg;
    act_dig_next   = act_dig_reg;
    act_dots_next  = act_dots_reg;
    act_blink_next = act_blink_reg;
    ack_next       = 1'b0;

    if (tick) begin
      idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
    end

    if (frame_end) begin
      if (frm_reg == FRM_MAX) begin
        frm_next   = '0;
        phase_next = ~phase_reg;
      end else begin
        frm_next = frm_reg + 1'b1;
      end
      if (pend_reg) begin
        act_dig_next   = stg_dig_reg;
        act_dots_next  = stg_dots_reg;
        act_blink_next = stg_blink_reg;
        pend_next      = 1'b0;
        ack_next       = 1'b1;
      end
    end

    // A load on the commit cycle re-arms pending after the old stage is committed.
    if (load) begin
      stg_dig_next   = digits;
      stg_dots_next  = dots;
      stg_blink_next = blink;
      pend_next      = 1'b1;
    end
  end

  // Outputs are derived from next-state values so they register together with the index.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_codes
      assign code_arr[gi] = act_dig_next[4*gi +: 4];
    end
  endgenerate

`ifdef SSEG_SCAN_LZB_EN
  logic [NDIG-1:0] lead_zero;
  logic            lz_run;

  always_comb begin
    lz_run    = 1'b1;
    lead_zero = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_run       = lz_run && (code_arr[i] == 4'h0);
      lead_zero[i] = lz_run;
    end
  end

  assign dec_code = (lead_zero[idx_next] && (idx_next != '0)) ? BLANK_CODE : code_arr[idx_next];
`else
  assign dec_code = code_arr[idx_next];
`endif

  seg_decode u_seg_decode (
    .code (dec_code),
    .sseg (dec_seg)
  );

  always_comb begin
    blink_blank = phase_next & act_blink_next[idx_next];
    an_next     = {{(NDIG-1){1'b0}}, 1'b1} << idx_next;
    sseg_next   = blink_blank ? 7'b0000000 : dec_seg;
    dot_next    = act_dots_next[idx_next] & ~blink_blank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      frm_reg       <= '0;
      phase_reg     <= 1'b0;
      pend_reg      <= 1'b0;
      stg_dig_reg   <= {NDIG{BLANK_CODE}};
      stg_dots_reg  <= '0;
      stg_blink_reg <= '0;
      act_dig_reg   <= {NDIG{BLANK_CODE}};
      act_dots_reg  <= '0;
      act_blink_reg <= '0;
      ack_reg       <= 1'b0;
      an_reg        <= {{(NDIG-1){1'b0}}, 1'b1};
      sseg_reg      <= '0;
      dot_reg       <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      frm_reg       <= frm_next;
      phase_reg     <= phase_next;
      pend_reg      <= pend_next;
      stg_dig_reg   <= stg_dig_next;
      stg_dots_reg  <= stg_dots_next;
      stg_blink_reg <= stg_blink_next;
      act_dig_reg   <= act_dig_next;
      act_dots_reg  <= act_dots_next;
      act_blink_reg <= act_blink_next;
      ack_reg       <= ack_next;
      an_reg        <= an_next;
      sseg_reg      <= sseg_next;
      dot_reg       <= dot_next;
    end
  end

  assign ack  = ack_reg;
  assign an   = an_reg;
  assign sseg = sseg_reg;
  assign dot  = dot_reg;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: timeline-based reference model plus directed literal checks.
module tb_sseg_scan_ctrl;

  localparam int NDIG         = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = SCAN_DIV * NDIG;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dots;
  logic [NDIG-1:0]   blink;
  logic              ack;
  logic [NDIG-1:0]   an;
  logic [6:0]        sseg;
  logic              dot;

  sseg_scan_ctrl #(
    .NDIG         (NDIG),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .digits (digits),
    .dots   (dots),
    .blink  (blink),
    .ack    (ack),
    .an     (an),
    .sseg   (sseg),
    .dot    (dot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;

  // Reference model: m_t counts clock edges since reset; the scan position follows from it by arithmetic.
  int                m_t = 0;
  bit                m_valid = 1'b0;
  bit                m_pend;
  bit                m_ack;
  logic [4*NDIG-1:0] m_dig, m_stg_dig;
  logic [NDIG-1:0]   m_dots, m_stg_dots, m_blink, m_stg_blink;

  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    logic [6:0] tbl [16];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011101,
            7'b0110111, 7'b0111101, 7'b1001111, 7'b0000000};
    return tbl[c];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, got, exp, m_t);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid     <= 1'b1;
      m_t         <= 0;
      m_pend      <= 1'b0;
      m_ack       <= 1'b0;
      m_dig       <= {NDIG{4'hF}};
      m_dots      <= '0;
      m_blink     <= '0;
    end else begin
      m_t <= m_t + 1;
      if ((((m_t + 1) % FRAME) == 0) && m_pend) begin
        m_dig   <= m_stg_dig;
        m_dots  <= m_stg_dots;
        m_blink <= m_stg_blink;
        m_ack   <= 1'b1;
        m_pend  <= 1'b0;
      end else begin
        m_ack <= 1'b0;
      end
      if (load) begin
        m_stg_dig   <= digits;
        m_stg_dots  <= dots;
        m_stg_blink <= blink;
        m_pend      <= 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  int         c_idx;
  bit         c_phase;
  bit         c_blank;
  bit         c_allz;
  logic [3:0] c_code;

  always @(negedge clk) begin
    if (m_valid) begin
      c_idx   = (m_t / SCAN_DIV) % NDIG;
      c_phase = (((m_t / FRAME) / BLINK_FRAMES) % 2) == 1;
      c_code  = m_dig[c_idx*4 +: 4];
`ifdef SSEG_SCAN_LZB_EN
      c_allz = 1'b1;
      for (int k = NDIG - 1; k >= c_idx; k--) begin
        if (m_dig[k*4 +: 4] != 4'h0) c_allz = 1'b0;
      end
      if (c_allz && c_idx != 0) c_code = 4'hF;
`else
      c_allz = 1'b0;
`endif
      c_blank = c_phase && m_blink[c_idx];
      chk("an", an, (1 << c_idx));
      chk("sseg", sseg, c_blank ? 7'd0 : ref_seg(c_code));
      chk("dot", dot, m_dots[c_idx] && !c_blank);
      chk("ack", ack, m_ack);
      if (ack === 1'b1) ack_cnt++;
    end
  end

  task automatic go_t(input int target);
    int g = 0;
    while (m_t != target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got t=%0d expected t=%0d", m_t, target);
    end
  endtask

  task automatic do_load(input logic [4*NDIG-1:0] d, input logic [NDIG-1:0] dp, input logic [NDIG-1:0] bl);
    digits = d;
    dots   = dp;
    blink  = bl;
    load   = 1'b1;
    $display("load digits=%h dots=%b blink=%b at t=%0d", d, dp, bl, m_t);
    @(negedge clk);
    load = 1'b0;
  endtask

  int a0;

  initial begin
    rst = 1'b1; load = 1'b0; digits = '0; dots = '0; blink = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_an", an, 4'b0001);
    chk("rst_sseg", sseg, 7'b0000000);
    chk("rst_dot", dot, 1'b0);
    chk("rst_ack", ack, 1'b0);

    go_t(3); chk("an_hold_t3", an, 4'b0001);
    go_t(4); chk("an_step_t4", an, 4'b0010);

    // Mid-frame load: nothing visible until the boundary.
    go_t(6); do_load(16'h1234, 4'b0100, 4'b0000);
    a0 = ack_cnt;
    go_t(8);  chk("pre_commit_seg", sseg, 7'b0000000);
    go_t(16); chk("commit_ack", ack, 1'b1);
    go_t(24); chk("d2_seg", sseg, 7'b1101101); chk("d2_dot", dot, 1'b1);
    chk("ack_once", ack_cnt - a0, 1);

    // Two loads in one frame: last write wins, one ack.
    go_t(34); do_load(16'h1111, 4'b0000, 4'b0000);
    a0 = ack_cnt;
    go_t(38); do_load(16'h2222, 4'b0000, 4'b0000);
    go_t(52); chk("lww_seg", sseg, 7'b1101101);
    go_t(63); chk("lww_acks", ack_cnt - a0, 1);

    // Load landing on the commit cycle.
    go_t(70); do_load(16'h5678, 4'b0000, 4'b0000);
    a0 = ack_cnt;
    go_t(79); do_load(16'h9ABC, 4'b0000, 4'b0000);
    go_t(80); chk("coll_ack1", ack, 1'b1); chk("coll_old_seg", sseg, 7'b1111111);
    go_t(96); chk("coll_ack2", ack, 1'b1); chk("coll_new_seg", sseg, 7'b0110111);
    go_t(100); chk("coll_acks", ack_cnt - a0, 2);

    // Blink on digit 0: frames 6-7 phase 1, frames 8-9 phase 0.
    do_load(16'h4321, 4'b0001, 4'b0001);
    go_t(112); chk("blink_off_seg", sseg, 7'b0000000); chk("blink_off_dot", dot, 1'b0);
    go_t(116); chk("blink_steady_d1", sseg, 7'b1101101);
    go_t(128); chk("blink_on_seg", sseg, 7'b0110000); chk("blink_on_dot", dot, 1'b1);

    // Reset while pending discards staged data.
    go_t(135); do_load(16'hEEEE, 4'b1111, 4'b0000);
    go_t(138);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a0 = ack_cnt;
    go_t(20);
    chk("rst_pend_acks", ack_cnt - a0, 0);
    chk("rst_pend_seg", sseg, 7'b0000000);

    // Leading-zero behaviour.
    do_load(16'h0050, 4'b0000, 4'b0000);
    go_t(32); chk("lz_d0", sseg, 7'b1111110);
    go_t(36); chk("lz_d1", sseg, 7'b1011011);
`ifdef SSEG_SCAN_LZB_EN
    go_t(40); chk("lz_d2", sseg, 7'b0000000);
    go_t(44); chk("lz_d3", sseg, 7'b0000000);
`else
    go_t(40); chk("lz_d2", sseg, 7'b1111110);
    go_t(44); chk("lz_d3", sseg, 7'b1111110);
`endif
    go_t(45); do_load(16'h0000, 4'b0000, 4'b0000);
    go_t(48); chk("zero_d0", sseg, 7'b1111110);
`ifdef SSEG_SCAN_LZB_EN
    go_t(52); chk("zero_d1", sseg, 7'b0000000);
`else
    go_t(52); chk("zero_d1", sseg, 7'b1111110);
`endif
    go_t(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
